// File: rtl/usb_mailbox_ctrl_pkg.sv
// Shared definitions for the USB/PicoRV32 mailbox controller.
//   - Mailbox and bus FSM state encodings
//   - Address-map region codes (top two bits of the window offset)
//   - STATUS bit positions and CTRL write masks
//   - pack_status(): assembles the STATUS word from its fields
package usb_mailbox_ctrl_pkg;

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_PENDING = 2'd1,
    M_DONE    = 2'd2
  } mbox_state_e;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_ACK  = 1'b1
  } bus_state_e;

  // Offset[MW+1:MW] selects one of four MB-sized regions.
  typedef enum logic [1:0] {
    REG_IN   = 2'd0,
    REG_OUT  = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } region_e;

  localparam int unsigned STAT_PENDING_BIT = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_OVR_BIT     = 2;
  localparam int unsigned STAT_CNT_LSB     = 16;

  // STATUS/CTRL lives at byte offset 0 of the control region.
  localparam int unsigned CTRL_OFFSET = 0;

  localparam logic [31:0] CTRL_ACK_MASK     = 32'h0000_0001;
  localparam logic [31:0] CTRL_OVR_CLR_MASK = 32'h0000_0004;

  function automatic logic [31:0] pack_status(input logic        pending,
                                              input logic        done,
                                              input logic        overrun,
                                              input logic [15:0] count);
    logic [31:0] w;
    w = '0;
    w[STAT_PENDING_BIT] = pending;
    w[STAT_DONE_BIT]    = done;
    w[STAT_OVR_BIT]     = overrun;
    w[STAT_CNT_LSB +: 16] = count;
    return w;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Level synchronizer with rising-edge detect.
//   clk_sys  in  clock
//   reset_n  in  asynchronous active-low reset
//   d        in  asynchronous level
//   q_sync   out synchronized level (after STAGES flops)
//   rise     out one-cycle pulse when q_sync goes 0->1
module sync_rise_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic d,
  output logic q_sync,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q_sync = r_sync[STAGES-1];
  assign rise   = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/usb_mailbox_ctrl.sv
// Mailbox controller between the USB host byte memories and the PicoRV32 native bus.
// The host fills memory_input and raises trigger; the block raises irq; the CPU reads
// the input window, writes the output window and writes ACK; done is held until the
// host drops trigger.
//   clk_sys        in  system clock
//   reset_n        in  asynchronous active-low reset
//   trigger        in  host doorbell (asynchronous level)
//   memory_input   in  host-written bytes, byte k = [8k+7:8k]
//   memory_output  out CPU-written bytes (registered)
//   mem_valid/addr/wdata/wstrb  in   PicoRV32 request
//   mem_ready/rdata             out  one-cycle acknowledge and read data
//   irq, busy      out high while PENDING
//   done           out high while DONE
module usb_mailbox_ctrl
  import usb_mailbox_ctrl_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned MEMORY_BYTES = 1 << MEMORY_WIDTH,
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      trigger,
  input  logic [MEMORY_BYTES*8-1:0] memory_input,
  output logic [MEMORY_BYTES*8-1:0] memory_output,
  input  logic                      mem_valid,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic [3:0]                mem_wstrb,
  output logic                      mem_ready,
  output logic [31:0]               mem_rdata,
  output logic                      irq,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned MW = MEMORY_WIDTH;
  localparam int unsigned OW = MW + 2;  // offset width across the 4*MB map
  localparam logic [MW-1:0] WORD_MASK = ~(MW'(3));

  // ---------------------------------------------------------------------------
  // Trigger synchronizer
  // ---------------------------------------------------------------------------
  logic w_sync;
  logic w_rise;

  sync_rise_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (trigger),
    .q_sync  (w_sync),
    .rise    (w_rise)
  );

  // ---------------------------------------------------------------------------
  // Address decode (base is aligned to 4*MB, so a tag compare suffices)
  // ---------------------------------------------------------------------------
  logic          w_hit;
  logic [OW-1:0] w_off;
  region_e       w_region;
  logic [MW-1:0] w_base;

  assign w_hit    = (mem_addr[31:OW] == BASE_ADDR[31:OW]);
  assign w_off    = mem_addr[OW-1:0];
  assign w_region = region_e'(w_off[OW-1:MW]);
  assign w_base   = w_off[MW-1:0] & WORD_MASK;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bus_state_e  r_bus_state;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [OW-1:0] r_off;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  mbox_state_e r_mbox_state;
  logic        r_irq;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;
  logic [15:0] r_db_count;

  logic [MEMORY_BYTES-1:0][7:0] r_out;
  logic [MEMORY_BYTES-1:0][7:0] w_in_bytes;

  assign w_in_bytes    = memory_input;
  assign memory_output = r_out;

  // ---------------------------------------------------------------------------
  // Read mux, evaluated at claim time and registered into r_rdata
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    unique case (w_region)
      REG_IN: begin
        for (int j = 0; j < 4; j++) begin
          w_rdata[8*j +: 8] = w_in_bytes[w_base + MW'(j)];
        end
      end
      REG_OUT: begin
        for (int j = 0; j < 4; j++) begin
          w_rdata[8*j +: 8] = r_out[w_base + MW'(j)];
        end
      end
      REG_CTRL: begin
        if (w_off[MW-1:0] == MW'(CTRL_OFFSET)) begin
          w_rdata = pack_status(r_busy, r_done, r_overrun, r_db_count);
        end
      end
      default: w_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus FSM: claim in B_IDLE, ack for one cycle in B_ACK. The request is latched
  // at claim so the write commits from stable values on the ack cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_state <= B_IDLE;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      unique case (r_bus_state)
        B_IDLE: begin
          r_ready <= 1'b0;
          r_rdata <= '0;
          if (mem_valid && w_hit) begin
            r_bus_state <= B_ACK;
            r_ready     <= 1'b1;
            r_rdata     <= w_rdata;
            r_off       <= w_off;
            r_wdata     <= mem_wdata;
            r_wstrb     <= mem_wstrb;
          end
        end
        B_ACK: begin
          r_bus_state <= B_IDLE;
          r_ready     <= 1'b0;
          r_rdata     <= '0;
        end
        default: begin
          r_bus_state <= B_IDLE;
          r_ready     <= 1'b0;
          r_rdata     <= '0;
        end
      endcase
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;

  // ---------------------------------------------------------------------------
  // Write commit decode (active only during the ack cycle)
  // ---------------------------------------------------------------------------
  region_e       w_r_region;
  logic [MW-1:0] w_r_base;
  logic          w_commit;
  logic          w_ctrl_wr;
  logic          w_out_wr;
  logic          w_ack_wr;
  logic          w_ovr_clr;

  assign w_r_region = region_e'(r_off[OW-1:MW]);
  assign w_r_base   = r_off[MW-1:0] & WORD_MASK;
  assign w_commit   = (r_bus_state == B_ACK) && (r_wstrb != 4'b0000);
  assign w_out_wr   = w_commit && (w_r_region == REG_OUT);
  assign w_ctrl_wr  = w_commit && (w_r_region == REG_CTRL) &&
                      (r_off[MW-1:0] == MW'(CTRL_OFFSET)) && r_wstrb[0];
  assign w_ack_wr   = w_ctrl_wr && ((r_wdata & CTRL_ACK_MASK) != '0);
  assign w_ovr_clr  = w_ctrl_wr && ((r_wdata & CTRL_OVR_CLR_MASK) != '0);

  // Output window bytes; input-window and reserved writes fall through unused.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (w_out_wr) begin
      for (int j = 0; j < 4; j++) begin
        if (r_wstrb[j]) begin
          r_out[w_r_base + MW'(j)] <= r_wdata[8*j +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mailbox FSM with registered irq/busy/done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mbox_state <= M_IDLE;
      r_irq        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_db_count   <= '0;
    end else begin
      // Every doorbell edge is counted, whatever the state.
      if (w_rise) begin
        r_db_count <= r_db_count + 16'd1;
      end

      // A doorbell while still pending is an overrun; set beats clear.
      if (w_rise && (r_mbox_state == M_PENDING)) begin
        r_overrun <= 1'b1;
      end else if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end

      unique case (r_mbox_state)
        M_IDLE: begin
          if (w_rise) begin
            r_mbox_state <= M_PENDING;
            r_irq        <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        M_PENDING: begin
          if (w_ack_wr) begin
            r_mbox_state <= M_DONE;
            r_irq        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        M_DONE: begin
          // Host must release the doorbell before a new exchange can start.
          if (!w_sync) begin
            r_mbox_state <= M_IDLE;
            r_done       <= 1'b0;
          end
        end
        default: begin
          r_mbox_state <= M_IDLE;
          r_irq        <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign irq  = r_irq;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_usb_mailbox_ctrl.sv
// Scoreboard bench for usb_mailbox_ctrl: bus requests push their expected read data,
// a monitor pops and compares on every mem_ready. Level outputs are checked inline.
module tb_usb_mailbox_ctrl;

  localparam int unsigned MW   = 8;
  localparam int unsigned MB   = 1 << MW;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] OUTB = BASE + MB;
  localparam logic [31:0] CTRL = BASE + 2 * MB;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b1;
  logic              trigger = 1'b0;
  logic [MB*8-1:0]   memory_input = '0;
  logic [MB*8-1:0]   memory_output;
  logic              mem_valid = 1'b0;
  logic [31:0]       mem_addr  = '0;
  logic [31:0]       mem_wdata = '0;
  logic [3:0]        mem_wstrb = '0;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              irq;
  logic              busy;
  logic              done;

  always #5 clk_sys = ~clk_sys;

  usb_mailbox_ctrl #(
    .MEMORY_WIDTH (MW),
    .BASE_ADDR    (BASE),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .trigger       (trigger),
    .memory_input  (memory_input),
    .memory_output (memory_output),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .irq           (irq),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic        is_read;
    logic [31:0] exp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: one pop per acknowledged request.
  always @(negedge clk_sys) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got rdata 0x%08h with no request pending", mem_rdata);
      end else begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.is_read) check(n, mem_rdata, e.exp);
      end
    end
  end

  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp,
                          input string name);
    exp_t e;
    int   lat;
    @(negedge clk_sys);
    e.is_read = (wstrb == 4'b0000);
    e.exp     = exp;
    exp_q.push_back(e);
    name_q.push_back(name);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    lat = 0;
    do begin
      @(posedge clk_sys);
      #1;
      lat++;
    end while (mem_ready !== 1'b1 && lat < 8);
    check({name, "_latency"}, 32'(lat), 32'd1);
    // Hold the request through the ack cycle, then release.
    @(posedge clk_sys);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus_xfer(addr, 32'h0, 4'b0000, exp, name);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input string name);
    bus_xfer(addr, data, strb, 32'h0, name);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic pulse_trigger();
    @(negedge clk_sys);
    trigger = 1'b1;
    repeat (4) @(negedge clk_sys);
    trigger = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic no_ack;
    logic rd_nonzero;

    // ---- 1: reset, then reset in the middle of an ack ----
    #1 reset_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_flags", {29'b0, irq, busy, done}, 32'h0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    memory_input[31:0] = 32'h4433_2211;
    @(negedge clk_sys);
    mem_valid = 1'b1;
    mem_addr  = BASE;
    mem_wstrb = 4'b0000;
    @(posedge clk_sys);
    #1;
    check("pre_rst_ready", {31'b0, mem_ready}, 32'h1);
    check("pre_rst_rdata", mem_rdata, 32'h4433_2211);
    #1 reset_n = 1'b0;
    #1;
    check("midack_ready", {31'b0, mem_ready}, 32'h0);
    check("midack_rdata", mem_rdata, 32'h0);
    mem_valid = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("post_rst_ready", {31'b0, mem_ready}, 32'h0);

    // ---- 2: input window reads ----
    memory_input[MB*8-1 -: 32] = 32'hDEAD_BEEF;
    rd(BASE, 32'h4433_2211, "in_w0");
    rd(BASE + MB - 4, 32'hDEAD_BEEF, "in_wlast");
    wr(BASE, 32'h5555_5555, 4'b1111, "in_write");
    rd(BASE, 32'h4433_2211, "in_w0_after_write");

    // ---- 3: output window byte strobes, reserved space ----
    wr(OUTB + 4, 32'hAABB_CCDD, 4'b0101, "out_w1");
    check("mem_out_w1", memory_output[63:32], 32'h00BB_00DD);
    rd(OUTB + 4, 32'h00BB_00DD, "out_w1_rd");
    wr(OUTB + MB - 4, 32'h1234_5678, 4'b1111, "out_wlast");
    rd(OUTB + MB - 4, 32'h1234_5678, "out_wlast_rd");
    wr(CTRL + 4, 32'hFFFF_FFFF, 4'b1111, "rsvd_wr");
    rd(CTRL + 4, 32'h0, "rsvd_rd");

    // ---- 4: doorbell handshake ----
    rd(CTRL, 32'h0000_0000, "stat_idle");
    wr(CTRL, 32'h1, 4'b0001, "ack_idle");
    rd(CTRL, 32'h0000_0000, "stat_ack_idle");
    @(negedge clk_sys);
    trigger = 1'b1;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    check("irq_early", {31'b0, irq}, 32'h0);
    @(posedge clk_sys);
    #1;
    check("irq_lat", {29'b0, irq, busy, done}, 32'h6);
    rd(CTRL, 32'h0001_0001, "stat_pend");
    wr(CTRL, 32'h1, 4'b0001, "ack_pend");
    check("after_ack", {29'b0, irq, busy, done}, 32'h1);
    rd(CTRL, 32'h0001_0002, "stat_done");
    @(negedge clk_sys);
    trigger = 1'b0;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    check("done_hold", {31'b0, done}, 32'h1);
    @(posedge clk_sys);
    #1;
    check("done_drop", {31'b0, done}, 32'h0);
    check("mem_out_kept", memory_output[63:32], 32'h00BB_00DD);

    // ---- 5: overrun ----
    do_reset();
    check("mem_out_rst", memory_output[63:32], 32'h0);
    pulse_trigger();
    pulse_trigger();
    rd(CTRL, 32'h0002_0005, "stat_ovr");
    wr(CTRL, 32'h4, 4'b0001, "ovr_clr");
    rd(CTRL, 32'h0002_0001, "stat_ovr_clr");
    // Align the clear with a doorbell edge: set must win.
    @(negedge clk_sys);
    trigger = 1'b1;
    wr(CTRL, 32'h4, 4'b0001, "ovr_clr_race");
    rd(CTRL, 32'h0003_0005, "stat_set_wins");
    @(negedge clk_sys);
    trigger = 1'b0;
    repeat (4) @(negedge clk_sys);
    // ACK on the same cycle as a doorbell edge: DONE with overrun.
    trigger = 1'b1;
    wr(CTRL, 32'h1, 4'b0001, "ack_race");
    rd(CTRL, 32'h0004_0006, "stat_ack_race");
    @(negedge clk_sys);
    trigger = 1'b0;
    repeat (4) @(negedge clk_sys);
    rd(CTRL, 32'h0004_0004, "stat_back_idle");
    wr(CTRL, 32'h4, 4'b0001, "ovr_clr2");

    // ---- 6: misses and count wrap ----
    no_ack = 1'b1;
    rd_nonzero = 1'b0;
    @(negedge clk_sys);
    mem_valid = 1'b1;
    mem_wstrb = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      mem_addr = (i < 5) ? (BASE - 4) : (BASE + 4 * MB);
      @(posedge clk_sys);
      #1;
      if (mem_ready !== 1'b0) no_ack = 1'b0;
      if (mem_rdata !== 32'h0) rd_nonzero = 1'b1;
    end
    mem_valid = 1'b0;
    check("miss_no_ack", {31'b0, no_ack}, 32'h1);
    check("miss_rdata", {31'b0, rd_nonzero}, 32'h0);

    @(negedge clk_sys);
    force dut.r_db_count = 16'hFFFF;
    @(negedge clk_sys);
    release dut.r_db_count;
    rd(CTRL, 32'hFFFF_0000, "stat_preset");
    pulse_trigger();
    rd(CTRL, 32'h0000_0001, "stat_wrap");

    repeat (3) @(negedge clk_sys);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
